// File: rtl/prism_config_reader_pkg.sv
// rtl/prism_config_reader_pkg.sv - shared FSM states and register map for the PRISM config read-back path
package prism_config_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_COPY,
      ST_VALID
   } rd_state_t;

   localparam logic [5:0] ADDR_RD_CTRL  = 6'h14;
   localparam logic [5:0] ADDR_RD_DATA0 = 6'h18;
   localparam logic [5:0] ADDR_RD_DATA1 = 6'h1C;
   localparam logic [5:0] ADDR_RD_DATA2 = 6'h20;

   localparam int CTRL_VALID_BIT   = 7;
   localparam int CTRL_AUTOINC_BIT = 8;
   localparam int CTRL_BUSY_BIT    = 9;

   localparam logic [1:0] XFER_NONE = 2'b11;

endpackage

// File: rtl/prism_config_reader_if.sv
// rtl/prism_config_reader_if.sv - TinyQV peripheral bus bundle for the config reader
interface prism_config_reader_if;

   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic [31:0] data_out;
   logic        data_ready;

   modport master (
      output address, data_in, data_write_n, data_read_n,
      input  data_out, data_ready
   );

   modport slave (
      input  address, data_in, data_write_n, data_read_n,
      output data_out, data_ready
   );

endinterface

// File: rtl/prism_chunk_mux.sv
// rtl/prism_chunk_mux.sv - selects chunk k of entry index from the flattened latch array
module prism_chunk_mux #(
   parameter int WIDTH = 80,
   parameter int DEPTH = 8,
   parameter int CHUNK = 16,
   parameter int IW    = 3,
   parameter int KW    = 3
) (
   input  logic [WIDTH*DEPTH-1:0] config_bus,
   input  logic [IW-1:0]          index,
   input  logic [KW-1:0]          k,
   output logic [CHUNK-1:0]       chunk
);

   // Out-of-range selections (non power-of-two DEPTH) read as zero.
   always_comb begin
      chunk = '0;
      if (int'(index) < DEPTH && int'(k) < WIDTH / CHUNK)
         chunk = config_bus[int'(index) * WIDTH + int'(k) * CHUNK +: CHUNK];
   end

endmodule

// File: rtl/prism_config_reader.sv
// rtl/prism_config_reader.sv - snapshots one latch-array entry into a shadow register, chunk by chunk
// and exposes it as RD_CTRL / RD_DATA0..2, stalling data reads while a capture is in flight.
module prism_config_reader
   import prism_config_reader_pkg::*;
#(
   parameter int WIDTH = 80,
   parameter int DEPTH = 8,
   parameter int CHUNK = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   prism_config_reader_if.slave   bus,
   input  logic [WIDTH*DEPTH-1:0] config_bus,
   input  logic                   config_busy,
   output logic                   capture_done
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

   rd_state_t        state;
   logic [IW-1:0]    index;
   logic             autoinc;
   logic             valid;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] shadow;

   logic [CHUNK-1:0] chunk;
   logic [95:0]      shadow_ext;
   logic [31:0]      ctrl_word;
   logic             busy;
   logic             rd_active;
   logic             ctrl_write;
   logic             data_sel;
   logic             autoinc_hit;
   logic             unused_data_in;

   prism_chunk_mux #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CHUNK (CHUNK),
      .IW    (IW),
      .KW    (KW)
   ) u_chunk_mux (
      .config_bus (config_bus),
      .index      (index),
      .k          (k),
      .chunk      (chunk)
   );

   assign busy       = (state == ST_WAIT) || (state == ST_COPY);
   assign rd_active  = bus.data_read_n != XFER_NONE;
   assign ctrl_write = (bus.data_write_n != XFER_NONE) && (bus.address == ADDR_RD_CTRL);
   assign data_sel   = (bus.address == ADDR_RD_DATA0) || (bus.address == ADDR_RD_DATA1) ||
                       (bus.address == ADDR_RD_DATA2);

   // Only shadow reads stall; they must never observe a half-copied entry.
   assign bus.data_ready = !(rd_active && data_sel && busy);

   assign autoinc_hit = (state == ST_VALID) && autoinc && rd_active &&
                        (bus.address == ADDR_RD_DATA2) && bus.data_ready;

   assign shadow_ext     = 96'(shadow);
   assign unused_data_in = ^bus.data_in;

   always_comb begin
      ctrl_word                   = '0;
      ctrl_word[IW-1:0]           = index;
      ctrl_word[CTRL_VALID_BIT]   = valid;
      ctrl_word[CTRL_AUTOINC_BIT] = autoinc;
      ctrl_word[CTRL_BUSY_BIT]    = busy;
   end

   always_comb begin
      case (bus.address)
         ADDR_RD_CTRL:  bus.data_out = ctrl_word;
         ADDR_RD_DATA0: bus.data_out = shadow_ext[31:0];
         ADDR_RD_DATA1: bus.data_out = shadow_ext[63:32];
         ADDR_RD_DATA2: bus.data_out = {16'h0, shadow_ext[79:64]};
         default:       bus.data_out = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         index        <= '0;
         autoinc      <= 1'b0;
         valid        <= 1'b0;
         k            <= '0;
         shadow       <= '0;
         capture_done <= 1'b0;
      end else begin
         capture_done <= 1'b0;
         if (ctrl_write) begin
            index   <= bus.data_in[IW-1:0];
            autoinc <= bus.data_in[CTRL_AUTOINC_BIT];
            valid   <= 1'b0;
            k       <= '0;
            state   <= ST_WAIT;
         end else begin
            case (state)
               ST_WAIT: begin
                  if (!config_busy)
                     state <= ST_COPY;
               end
               ST_COPY: begin
                  // A loader write mid-copy could tear the entry, so start over from chunk 0.
                  if (config_busy) begin
                     k     <= '0;
                     state <= ST_WAIT;
                  end else begin
                     shadow[int'(k) * CHUNK +: CHUNK] <= chunk;
                     if (k == KW'(NCH - 1)) begin
                        k            <= '0;
                        valid        <= 1'b1;
                        capture_done <= 1'b1;
                        state        <= ST_VALID;
                     end else begin
                        k <= k + 1'b1;
                     end
                  end
               end
               ST_VALID: begin
                  if (autoinc_hit) begin
                     index <= (index == IW'(DEPTH - 1)) ? '0 : index + 1'b1;
                     valid <= 1'b0;
                     state <= ST_WAIT;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prism_config_reader.sv
// tb/tb_prism_config_reader.sv - self-checking bench for prism_config_reader
module tb_prism_config_reader;

   localparam int WIDTH = 80;
   localparam int DEPTH = 8;
   localparam int CHUNK = 16;

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] exp;
      string       name;
   } vec_t;

   logic                   clk;
   logic                   rst;
   logic [WIDTH*DEPTH-1:0] config_bus;
   logic                   config_busy;
   logic                   capture_done;

   prism_config_reader_if bus ();

   prism_config_reader #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CHUNK (CHUNK)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .config_bus   (config_bus),
      .config_busy  (config_busy),
      .capture_done (capture_done)
   );

   int          n_pass = 0;
   int          n_total = 0;
   int          cd_count = 0;
   int          cd_base;
   logic [79:0] ent [DEPTH];
   logic [31:0] sb_q [$];
   vec_t        vecs [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (capture_done) cd_count <= cd_count + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic set_entry(input int i, input logic [79:0] v);
      ent[i] = v;
      config_bus[i*WIDTH +: WIDTH] = v;
   endtask

   task automatic bus_write(input logic [5:0] addr, input logic [31:0] data, input logic [1:0] wn);
      @(posedge clk);
      #1;
      bus.address      = addr;
      bus.data_in      = data;
      bus.data_write_n = wn;
      @(posedge clk);
      #1;
      bus.data_write_n = 2'b11;
   endtask

   // Issue a read, count stalled cycles, compare the completed value from the scoreboard.
   task automatic timed_read(input logic [5:0] addr, input logic [31:0] exp, input int exp_stall,
                             input int exp_cd, input string name);
      int   stalls;
      bit   got;
      logic [31:0] e;
      sb_q.push_back(exp);
      bus.address     = addr;
      bus.data_read_n = 2'b10;
      stalls = 0;
      got    = 1'b0;
      for (int c = 0; c < 64 && !got; c++) begin
         @(negedge clk);
         if (bus.data_ready) got = 1'b1;
         else stalls++;
      end
      if (!got) check({name, "_timeout"}, 32'(got), 32'd1);
      if (exp_stall >= 0) check({name, "_stall"}, 32'(stalls), 32'(exp_stall));
      if (exp_cd >= 0) check({name, "_capture_done"}, 32'(capture_done), 32'(exp_cd));
      e = sb_q.pop_front();
      check(name, bus.data_out, e);
      @(posedge clk);
      #1;
      bus.data_read_n = 2'b11;
   endtask

   initial begin
      rst              = 1'b1;
      config_busy      = 1'b0;
      config_bus       = '0;
      bus.address      = '0;
      bus.data_in      = '0;
      bus.data_write_n = 2'b11;
      bus.data_read_n  = 2'b11;
      for (int i = 0; i < DEPTH; i++) set_entry(i, 80'({$urandom, $urandom, $urandom}));
      set_entry(3, 80'h1234_89ABCDEF_01234567);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("reset_capture_done", 32'(capture_done), 32'd0);
      timed_read(6'h18, 32'h0, 0, 0, "reset_data0");
      timed_read(6'h14, 32'h0, 0, -1, "reset_ctrl");

      // Basic capture of entry 3 with a read stalled from T+1
      bus_write(6'h14, 32'h003, 2'b10);
      timed_read(6'h1C, 32'h89ABCDEF, 6, 1, "cap3_data1");
      timed_read(6'h20, 32'h00001234, 0, -1, "cap3_data2");

      vecs[0] = '{6'h14, 32'h0000_0083, "tbl_ctrl"};
      vecs[1] = '{6'h18, 32'h0123_4567, "tbl_data0"};
      vecs[2] = '{6'h1C, 32'h89AB_CDEF, "tbl_data1"};
      vecs[3] = '{6'h20, 32'h0000_1234, "tbl_data2"};
      vecs[4] = '{6'h00, 32'h0, "tbl_addr00"};
      vecs[5] = '{6'h10, 32'h0, "tbl_addr10"};
      vecs[6] = '{6'h24, 32'h0, "tbl_addr24"};
      vecs[7] = '{6'h3C, 32'h0, "tbl_addr3c"};
      for (int i = 0; i < 8; i++) timed_read(vecs[i].addr, vecs[i].exp, 0, -1, vecs[i].name);

      // Writes to data registers are ignored
      bus_write(6'h18, 32'hFFFF_FFFF, 2'b10);
      timed_read(6'h14, 32'h0000_0083, 0, -1, "wr_data_ctrl");
      timed_read(6'h18, 32'h0123_4567, 0, -1, "wr_data_data0");

      // Loader busy during second COPY cycle: entry changes, capture restarts from chunk 0
      bus_write(6'h14, 32'h003, 2'b10);
      fork
         begin
            repeat (2) @(posedge clk);
            #1;
            config_busy = 1'b1;
            set_entry(3, 80'hBEEF_CAFEF00D_5A5AA5A5);
            repeat (3) @(posedge clk);
            #1 config_busy = 1'b0;
         end
         timed_read(6'h18, 32'h5A5AA5A5, 11, 1, "busy_data0");
      join
      timed_read(6'h1C, 32'hCAFEF00D, 0, -1, "busy_data1");
      timed_read(6'h20, 32'h0000_BEEF, 0, -1, "busy_data2");

      // Auto-increment wraps from 7 to 0
      bus_write(6'h14, 32'h107, 2'b10);
      timed_read(6'h20, {16'h0, ent[7][79:64]}, 6, 1, "auto_data2");
      bus.address     = 6'h14;
      bus.data_read_n = 2'b10;
      @(negedge clk);
      check("auto_ctrl_ready", 32'(bus.data_ready), 32'd1);
      check("auto_ctrl", bus.data_out & 32'hFFFF_FF7F, 32'h0000_0300);
      @(posedge clk);
      #1 bus.data_read_n = 2'b11;
      timed_read(6'h18, ent[0][31:0], -1, -1, "auto_wrap_data0");

      // RD_CTRL write during COPY aborts the running capture
      cd_base = cd_count;
      bus_write(6'h14, 32'h005, 2'b10);
      @(posedge clk);
      bus_write(6'h14, 32'h002, 2'b01);
      timed_read(6'h18, ent[2][31:0], 6, 1, "abort_data0");
      timed_read(6'h1C, ent[2][63:32], 0, -1, "abort_data1");
      timed_read(6'h20, {16'h0, ent[2][79:64]}, 0, -1, "abort_data2");
      repeat (3) @(posedge clk);
      check("abort_pulses", 32'(cd_count - cd_base), 32'd1);

      // Reset mid-COPY
      bus_write(6'h14, 32'h004, 2'b00);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_capture_done", 32'(capture_done), 32'd0);
      timed_read(6'h1C, 32'h0, 0, -1, "rst_data1");
      timed_read(6'h14, 32'h0, 0, -1, "rst_ctrl");
      timed_read(6'h20, 32'h0, 0, -1, "rst_data2");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
